// File: rtl/sw_pkg.sv
// Shared definitions for the button conditioner: the debounce FSM state encoding,
// the counter width and the default timing parameters.
package sw_pkg;

  localparam int CNT_W = 16;

  localparam int DEBOUNCE_CYCLES_DEF = 16;
  localparam int HOLD_CYCLES_DEF     = 64;
  localparam int REPEAT_CYCLES_DEF   = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_HELD    = 3'd2,
    ST_REPEAT  = 3'd3,
    ST_RELEASE = 3'd4
  } btn_state_t;

endpackage

// File: rtl/button_conditioner_if.sv
// Raw front-panel inputs and conditioned outputs of the button conditioner.
// master drives the raw buttons and switches; slave is the conditioner itself.
interface button_conditioner_if;

  logic       inc_raw;
  logic       dec_raw;
  logic       rst_raw;
  logic       pause_raw;
  logic       down_raw;
  logic       adj_raw;
  logic       adj_b_raw;
  logic [1:0] sel_raw;

  logic       inc_btn;
  logic       dec_btn;
  logic       rst_btn;
  logic       pause_btn;
  logic       down_sw;
  logic       adj_sw;
  logic       adj_sw_b;
  logic [1:0] sel_sw;

  modport master (
    output inc_raw, dec_raw, rst_raw, pause_raw, down_raw, adj_raw, adj_b_raw, sel_raw,
    input  inc_btn, dec_btn, rst_btn, pause_btn, down_sw, adj_sw, adj_sw_b, sel_sw
  );

  modport slave (
    input  inc_raw, dec_raw, rst_raw, pause_raw, down_raw, adj_raw, adj_b_raw, sel_raw,
    output inc_btn, dec_btn, rst_btn, pause_btn, down_sw, adj_sw, adj_sw_b, sel_sw
  );

endinterface

// File: rtl/btn_debounce.sv
// One push-button channel: 2-flop synchronizer, debounce/auto-repeat FSM and a
// 16-bit timer, producing a registered single-cycle pulse per accepted event.
//
// state      | meaning
// IDLE       | button released and stable
// ARM        | press seen, counting stable samples before accepting it
// HELD       | press accepted, timing towards first auto-repeat
// REPEAT     | auto-repeating every REPEAT_CYCLES
// RELEASE    | release seen, counting stable samples before returning to IDLE
module btn_debounce
  import sw_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int HOLD_CYCLES     = HOLD_CYCLES_DEF,
  parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic repeat_en,
  output logic pulse
);

  localparam logic [CNT_W-1:0] DEB_TC  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_TC = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_TC  = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             sync_q1;
  logic             sync_q2;
  btn_state_t       state;
  btn_state_t       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             pulse_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      state   <= ST_IDLE;
      cnt     <= '0;
      pulse   <= 1'b0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pulse   <= pulse_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (sync_q2) state_nxt = ST_ARM;
      ST_ARM: begin
        if (!sync_q2)          state_nxt = ST_IDLE;
        else if (cnt == DEB_TC) state_nxt = ST_HELD;
      end
      ST_HELD: begin
        if (!sync_q2)                          state_nxt = ST_RELEASE;
        else if (repeat_en && cnt == HOLD_TC)  state_nxt = ST_REPEAT;
      end
      ST_REPEAT:  if (!sync_q2) state_nxt = ST_RELEASE;
      ST_RELEASE: begin
        if (sync_q2)            state_nxt = ST_HELD;
        else if (cnt == DEB_TC) state_nxt = ST_IDLE;
      end
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_nxt   = cnt;
    pulse_nxt = 1'b0;
    case (state)
      ST_IDLE:    cnt_nxt = sync_q2 ? CNT_ONE : '0;
      ST_ARM: begin
        if (!sync_q2) begin
          cnt_nxt = '0;
        end else if (cnt == DEB_TC) begin
          cnt_nxt   = '0;
          pulse_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      ST_HELD: begin
        if (!sync_q2) begin
          cnt_nxt = CNT_ONE;
        end else if (repeat_en && cnt == HOLD_TC) begin
          cnt_nxt   = '0;
          pulse_nxt = 1'b1;
        end else if (cnt != CNT_MAX) begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      ST_REPEAT: begin
        // Losing repeat_en mid-repeat keeps the cadence but silences the pulses.
        if (!sync_q2) begin
          cnt_nxt = CNT_ONE;
        end else if (cnt == REP_TC) begin
          cnt_nxt   = '0;
          pulse_nxt = repeat_en;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      ST_RELEASE: begin
        if (sync_q2 || cnt == DEB_TC) cnt_nxt = '0;
        else                          cnt_nxt = cnt + CNT_ONE;
      end
      default:    cnt_nxt = '0;
    endcase
  end

endmodule

// File: rtl/button_conditioner.sv
// Front-panel conditioner for the stopwatch: four debounced push-buttons with
// auto-repeat on inc/dec, plain 2-flop synchronizers for the slide/select switches.
module button_conditioner
  import sw_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int HOLD_CYCLES     = HOLD_CYCLES_DEF,
  parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  button_conditioner_if.slave  bus
);

  logic [4:0] sw_q1;
  logic [4:0] sw_q2;
  logic       inc_pulse;
  logic       dec_pulse;
  logic       rst_pulse;
  logic       pause_pulse;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sw_q1 <= '0;
      sw_q2 <= '0;
    end else begin
      sw_q1 <= {bus.sel_raw, bus.adj_b_raw, bus.adj_raw, bus.down_raw};
      sw_q2 <= sw_q1;
    end
  end

  assign bus.down_sw  = sw_q2[0];
  assign bus.adj_sw   = sw_q2[1];
  assign bus.adj_sw_b = sw_q2[2];
  assign bus.sel_sw   = sw_q2[4:3];

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .HOLD_CYCLES     (HOLD_CYCLES),
    .REPEAT_CYCLES   (REPEAT_CYCLES)
  ) u_inc (
    .clk       (clk),
    .rst_n     (rst_n),
    .raw       (bus.inc_raw),
    .repeat_en (sw_q2[1]),
    .pulse     (inc_pulse)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .HOLD_CYCLES     (HOLD_CYCLES),
    .REPEAT_CYCLES   (REPEAT_CYCLES)
  ) u_dec (
    .clk       (clk),
    .rst_n     (rst_n),
    .raw       (bus.dec_raw),
    .repeat_en (sw_q2[1]),
    .pulse     (dec_pulse)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .HOLD_CYCLES     (HOLD_CYCLES),
    .REPEAT_CYCLES   (REPEAT_CYCLES)
  ) u_rst (
    .clk       (clk),
    .rst_n     (rst_n),
    .raw       (bus.rst_raw),
    .repeat_en (1'b0),
    .pulse     (rst_pulse)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .HOLD_CYCLES     (HOLD_CYCLES),
    .REPEAT_CYCLES   (REPEAT_CYCLES)
  ) u_pause (
    .clk       (clk),
    .rst_n     (rst_n),
    .raw       (bus.pause_raw),
    .repeat_en (1'b0),
    .pulse     (pause_pulse)
  );

  // Simultaneous inc and dec is ambiguous, so neither reaches the stopwatch.
  assign bus.inc_btn   = inc_pulse & ~dec_pulse;
  assign bus.dec_btn   = dec_pulse & ~inc_pulse;
  assign bus.rst_btn   = rst_pulse;
  assign bus.pause_btn = pause_pulse;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner. Raw inputs change 1 ns after a rising edge;
// "edge k" is the k-th rising edge after that change (k=0 first samples it), and
// outputs are read 1 ns after edge k.
module tb_button_conditioner;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  button_conditioner_if bif ();

  button_conditioner #(
    .DEBOUNCE_CYCLES (16),
    .HOLD_CYCLES     (64),
    .REPEAT_CYCLES   (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_inputs;
    bif.inc_raw   = 1'b0;
    bif.dec_raw   = 1'b0;
    bif.rst_raw   = 1'b0;
    bif.pause_raw = 1'b0;
    bif.down_raw  = 1'b0;
    bif.adj_raw   = 1'b0;
    bif.adj_b_raw = 1'b0;
    bif.sel_raw   = 2'b00;
  endtask

  function automatic logic [8:0] outs();
    return {bif.inc_btn, bif.dec_btn, bif.rst_btn, bif.pause_btn,
            bif.down_sw, bif.adj_sw, bif.adj_sw_b, bif.sel_sw};
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    clear_inputs();
    bif.down_raw = 1'b1;
    bif.sel_raw  = 2'b11;
    settle(3);
    checks++;
    if (outs() !== 9'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=%b", outs(), 9'b0);
    end
    rst_n = 1'b1;
    settle(2);
    checks++;
    if ({bif.down_sw, bif.sel_sw} !== 3'b111) begin
      errors++;
      $display("FAIL reset_exit_switches got=%b exp=%b", {bif.down_sw, bif.sel_sw}, 3'b111);
    end
    clear_inputs();
    settle(4);
    checks++;
    if (outs() !== 9'b0) begin
      errors++;
      $display("FAIL reset_idle_outputs got=%b exp=%b", outs(), 9'b0);
    end
  endtask

  task automatic test_clean_press;
    bif.inc_raw = 1'b1;
    for (int k = 0; k < 70; k++) begin
      tick();
      checks++;
      if (bif.inc_btn !== (k == 18)) begin
        errors++;
        $display("FAIL clean_press inc_btn edge=%0d got=%b exp=%b", k, bif.inc_btn, (k == 18));
      end
      checks++;
      if (bif.dec_btn !== 1'b0) begin
        errors++;
        $display("FAIL clean_press dec_btn edge=%0d got=%b exp=0", k, bif.dec_btn);
      end
      if (k == 39) bif.inc_raw = 1'b0;
    end
  endtask

  task automatic test_bounce;
    bif.pause_raw = 1'b0;
    for (int t = 0; t < 6; t++) begin
      bif.pause_raw = ~bif.pause_raw;
      for (int c = 0; c < 3; c++) begin
        tick();
        checks++;
        if (bif.pause_btn !== 1'b0) begin
          errors++;
          $display("FAIL bounce_chatter pause_btn toggle=%0d got=%b exp=0", t, bif.pause_btn);
        end
      end
    end
    bif.pause_raw = 1'b1;
    for (int k = 0; k < 50; k++) begin
      tick();
      checks++;
      if (bif.pause_btn !== (k == 18)) begin
        errors++;
        $display("FAIL bounce_final pause_btn edge=%0d got=%b exp=%b", k, bif.pause_btn, (k == 18));
      end
      if (k == 29) bif.pause_raw = 1'b0;
    end
  endtask

  task automatic test_auto_repeat;
    logic exp;
    bif.adj_raw = 1'b1;
    settle(3);
    checks++;
    if (bif.adj_sw !== 1'b1) begin
      errors++;
      $display("FAIL auto_repeat adj_sw got=%b exp=1", bif.adj_sw);
    end
    bif.dec_raw = 1'b1;
    for (int k = 0; k < 240; k++) begin
      tick();
      exp = (k == 18) || (k >= 82 && k < 200 && ((k - 82) % 16 == 0));
      checks++;
      if (bif.dec_btn !== exp) begin
        errors++;
        $display("FAIL auto_repeat dec_btn edge=%0d got=%b exp=%b", k, bif.dec_btn, exp);
      end
      checks++;
      if (bif.inc_btn !== 1'b0) begin
        errors++;
        $display("FAIL auto_repeat inc_btn edge=%0d got=%b exp=0", k, bif.inc_btn);
      end
      if (k == 199) bif.dec_raw = 1'b0;
    end
  endtask

  task automatic test_adj_drop;
    logic exp;
    bif.inc_raw = 1'b1;
    for (int k = 0; k < 150; k++) begin
      tick();
      exp = (k == 18) || (k == 82);
      checks++;
      if (bif.inc_btn !== exp) begin
        errors++;
        $display("FAIL adj_drop inc_btn edge=%0d got=%b exp=%b", k, bif.inc_btn, exp);
      end
      if (k == 85)  bif.adj_raw = 1'b0;
      if (k == 119) bif.inc_raw = 1'b0;
    end
    settle(5);
  endtask

  task automatic test_conflict;
    bif.inc_raw   = 1'b1;
    bif.dec_raw   = 1'b1;
    bif.pause_raw = 1'b1;
    bif.rst_raw   = 1'b1;
    for (int k = 0; k < 60; k++) begin
      tick();
      checks++;
      if ({bif.inc_btn, bif.dec_btn} !== 2'b00) begin
        errors++;
        $display("FAIL conflict inc_dec edge=%0d got=%b exp=00", k, {bif.inc_btn, bif.dec_btn});
      end
      checks++;
      if ({bif.pause_btn, bif.rst_btn} !== {2{k == 18}}) begin
        errors++;
        $display("FAIL conflict pause_rst edge=%0d got=%b exp=%b", k,
                 {bif.pause_btn, bif.rst_btn}, {2{k == 18}});
      end
      if (k == 29) begin
        bif.inc_raw   = 1'b0;
        bif.dec_raw   = 1'b0;
        bif.pause_raw = 1'b0;
        bif.rst_raw   = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid_press;
    bif.down_raw = 1'b1;
    settle(3);
    bif.inc_raw = 1'b1;
    for (int k = 0; k < 70; k++) begin
      tick();
      checks++;
      if (k == 10) begin
        if (outs() !== 9'b0) begin
          errors++;
          $display("FAIL reset_mid_press outputs edge=%0d got=%b exp=%b", k, outs(), 9'b0);
        end
      end else if (bif.inc_btn !== (k == 29)) begin
        errors++;
        $display("FAIL reset_mid_press inc_btn edge=%0d got=%b exp=%b", k, bif.inc_btn, (k == 29));
      end
      if (k == 9)  rst_n = 1'b0;
      if (k == 10) rst_n = 1'b1;
      if (k == 39) bif.inc_raw = 1'b0;
    end
    bif.down_raw = 1'b0;
    settle(3);
  endtask

  task automatic test_short_and_release_bounce;
    bif.inc_raw = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      checks++;
      if (bif.inc_btn !== 1'b0) begin
        errors++;
        $display("FAIL short_press inc_btn edge=%0d got=%b exp=0", k, bif.inc_btn);
      end
      if (k == 9) bif.inc_raw = 1'b0;
    end
    bif.inc_raw = 1'b1;
    for (int k = 0; k < 90; k++) begin
      tick();
      checks++;
      if (bif.inc_btn !== (k == 18)) begin
        errors++;
        $display("FAIL release_bounce inc_btn edge=%0d got=%b exp=%b", k, bif.inc_btn, (k == 18));
      end
      if (k == 30) bif.inc_raw = 1'b0;
      if (k == 34) bif.inc_raw = 1'b1;
      if (k == 54) bif.inc_raw = 1'b0;
    end
  endtask

  task automatic test_switches;
    bif.sel_raw   = 2'b10;
    bif.adj_b_raw = 1'b1;
    tick();
    checks++;
    if ({bif.sel_sw, bif.adj_sw_b} !== 3'b000) begin
      errors++;
      $display("FAIL switches_edge0 got=%b exp=%b", {bif.sel_sw, bif.adj_sw_b}, 3'b000);
    end
    tick();
    checks++;
    if ({bif.sel_sw, bif.adj_sw_b} !== 3'b101) begin
      errors++;
      $display("FAIL switches_edge1 got=%b exp=%b", {bif.sel_sw, bif.adj_sw_b}, 3'b101);
    end
    clear_inputs();
    settle(3);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_auto_repeat();
    test_adj_drop();
    settle(20);
    test_conflict();
    test_reset_mid_press();
    test_short_and_release_bounce();
    test_switches();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
